// File: rtl/i2c_config_sequencer_if.sv
// Write-port bundle between the configuration sequencer and the I2C write master.
// The sequencer uses the master modport. The I2C master block uses the slave modport.
interface i2c_config_sequencer_if;
    logic [6:0] slav_addr;
    logic       read_not_write;
    logic [7:0] reg_addr;
    logic [7:0] write_data;
    logic       write_valid;
    logic       write_ready;
    logic       error;

    modport master (
        output slav_addr, read_not_write, reg_addr, write_data, write_valid,
        input  write_ready, error
    );

    modport slave (
        input  slav_addr, read_not_write, reg_addr, write_data, write_valid,
        output write_ready, error
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a codec configuration ROM and issues one I2C register write per entry, with delay entries and NACK handling.
// Define I2C_CFG_RETRY_EN to retry a NACKed entry up to MAX_RETRIES times before failing.
module i2c_config_sequencer #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
    parameter int         ADDR_W      = 6,
    parameter int         GAP_CYCLES  = 4,
    parameter int         DELAY_UNIT  = 20,
    parameter int         MAX_RETRIES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [15:0]           rom_data,
    i2c_config_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_W-1:0]     fail_index
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP,
        S_DELAY,
        S_ADVANCE,
        S_DONE,
        S_FAIL
`ifdef I2C_CFG_RETRY_EN
        , S_RETRY_GAP
`endif
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e      state, state_nxt;
    logic [15:0] cnt;
    logic [7:0]  reg_q, data_q;
    logic        is_end, is_delay, delay_zero, cnt_last;

    assign is_end     = (rom_data == 16'hFFFF);
    assign is_delay   = (rom_data[15:8] == 8'hFE);
    assign delay_zero = (rom_data[7:0] == 8'h00);
    assign cnt_last   = (cnt <= 16'd1);

`ifdef I2C_CFG_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_ok;
    assign retry_ok = (int'(retry_cnt) < MAX_RETRIES);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_FAIL: if (start) state_nxt = S_FETCH;
            S_FETCH:                state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_end)        state_nxt = S_DONE;
                else if (is_delay) state_nxt = delay_zero ? S_ADVANCE : S_DELAY;
                else               state_nxt = S_ISSUE;
            end
            S_ISSUE:     if (bus.write_ready)  state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!bus.write_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.write_ready) begin
                    if (!bus.error)    state_nxt = S_GAP;
`ifdef I2C_CFG_RETRY_EN
                    else if (retry_ok) state_nxt = S_RETRY_GAP;
`endif
                    else               state_nxt = S_FAIL;
                end
            end
            S_GAP:       if (cnt_last) state_nxt = S_ADVANCE;
            S_DELAY:     if (cnt_last) state_nxt = S_ADVANCE;
`ifdef I2C_CFG_RETRY_EN
            S_RETRY_GAP: if (cnt_last) state_nxt = S_ISSUE;
`endif
            S_ADVANCE:   state_nxt = (rom_addr == LAST_ADDR) ? S_DONE : S_FETCH;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.write_valid = (state == S_ISSUE);
        busy            = !(state inside {S_IDLE, S_DONE, S_FAIL});
        done            = (state == S_DONE);
        fail            = (state == S_FAIL);
    end

    assign bus.slav_addr      = SLAVE_ADDR;
    assign bus.read_not_write = 1'b0;
    assign bus.reg_addr       = reg_q;
    assign bus.write_data     = data_q;

    // One down-counter serves the post-write gap, the retry gap and delay entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            cnt        <= '0;
            fail_index <= '0;
`ifdef I2C_CFG_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        rom_addr  <= '0;
`ifdef I2C_CFG_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                S_DECODE: begin
                    if (is_delay) begin
                        cnt <= 16'(rom_data[7:0] * DELAY_UNIT);
                    end else if (!is_end) begin
                        reg_q  <= rom_data[15:8];
                        data_q <= rom_data[7:0];
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.write_ready) begin
                        cnt <= 16'(GAP_CYCLES);
                        if (bus.error) begin
`ifdef I2C_CFG_RETRY_EN
                            if (retry_ok) retry_cnt  <= retry_cnt + RETRY_W'(1);
                            else          fail_index <= rom_addr;
`else
                            fail_index <= rom_addr;
`endif
                        end
                    end
                end
`ifdef I2C_CFG_RETRY_EN
                S_GAP, S_DELAY, S_RETRY_GAP: cnt <= cnt - 16'd1;
`else
                S_GAP, S_DELAY: cnt <= cnt - 16'd1;
`endif
                S_ADVANCE: begin
                    if (rom_addr != LAST_ADDR) rom_addr <= rom_addr + ADDR_W'(1);
`ifdef I2C_CFG_RETRY_EN
                    retry_cnt <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench: a timeline model derived from the ROM contents and the master's per-attempt timing
// predicts write_valid/busy/done/fail and the write payload on every cycle of a walk.
module tb_i2c_config_sequencer;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int GAP    = 4;
    localparam int DUNIT  = 20;
    localparam int MAXR   = 3;
    localparam int MAXC   = 8192;
    localparam int MAXA   = 512;
`ifdef I2C_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr, fail_index;
    logic [15:0]       rom_data;
    logic              busy, done, fail;

    i2c_config_sequencer_if bus();

    i2c_config_sequencer #(
        .SLAVE_ADDR(7'h1A), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP),
        .DELAY_UNIT(DUNIT), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .bus(bus),
        .busy(busy), .done(done), .fail(fail), .fail_index(fail_index)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_mem [DEPTH];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-attempt master behaviour: ready stall before the handshake, busy length, NACK.
    int stall_a [MAXA];
    int len_a   [MAXA];
    bit nack_a  [MAXA];
    int att = 0;

    initial begin
        int s, l;
        bit nk;
        bus.write_ready = 1'b1;
        bus.error       = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.write_valid && rst_n) begin
                s = stall_a[att % MAXA];
                l = len_a[att % MAXA];
                nk = nack_a[att % MAXA];
                att++;
                if (s > 0) begin
                    bus.write_ready = 1'b0;
                    repeat (s) @(negedge clk);
                    bus.write_ready = 1'b1;
                end
                @(negedge clk);
                bus.write_ready = 1'b0;
                repeat (l) @(negedge clk);
                bus.write_ready = 1'b1;
                bus.error       = nk;
                @(negedge clk);
                bus.error       = 1'b0;
            end
        end
    end

    // Expected timeline, indexed by clock edges counted from the edge that samples start.
    bit       exp_valid [MAXC];
    bit [7:0] exp_reg   [MAXC];
    bit [7:0] exp_data  [MAXC];
    int exp_end, exp_attempts, exp_fail_index, first_valid;
    bit exp_is_fail;

    task automatic build_model();
        int t, idx, j, retries, n, s, l, w;
        bit fin, nk;
        logic [15:0] e;
        for (int c = 0; c < MAXC; c++) begin
            exp_valid[c] = 1'b0;
            exp_reg[c]   = '0;
            exp_data[c]  = '0;
        end
        t = 2; idx = 0; j = 0; retries = 0; fin = 1'b0;
        first_valid = -1; exp_is_fail = 1'b0; exp_fail_index = 0; exp_end = 0;
        while (!fin) begin
            e = rom_mem[idx];
            if (e == 16'hFFFF) begin
                exp_end = t; fin = 1'b1;
            end else if (e[15:8] == 8'hFE) begin
                n = int'(e[7:0]) * DUNIT;
                if (idx == DEPTH - 1) begin exp_end = t + n + 1; fin = 1'b1; end
                else begin t = t + n + 3; idx++; end
            end else begin
                s = stall_a[j]; l = len_a[j]; nk = nack_a[j]; j++;
                if (first_valid < 0) first_valid = t;
                for (int c = t; c <= t + s && c < MAXC; c++) begin
                    exp_valid[c] = 1'b1;
                    exp_reg[c]   = e[15:8];
                    exp_data[c]  = e[7:0];
                end
                w = t + s + l + 2;
                if (!nk) begin
                    retries = 0;
                    if (idx == DEPTH - 1) begin exp_end = w + GAP + 1; fin = 1'b1; end
                    else begin t = w + GAP + 3; idx++; end
                end else begin
                    retries++;
                    if (RETRY && retries <= MAXR) t = w + GAP;
                    else begin
                        exp_end = w; exp_is_fail = 1'b1; exp_fail_index = idx; fin = 1'b1;
                    end
                end
            end
            if (!fin && (j >= MAXA || t >= MAXC - 64)) begin exp_end = t; fin = 1'b1; end
        end
        exp_attempts = j;
    endtask

    // Single compare process: runs on every falling edge while a walk is being modelled.
    int       mc = 0;
    bit       model_on = 1'b0;
    logic [3:0] cmp_act, cmp_exp;
    always @(negedge clk) begin
        if (model_on) begin
            if (mc < MAXC) begin
                cmp_act = {bus.write_valid, busy, done, fail};
                cmp_exp = {exp_valid[mc], mc < exp_end, mc >= exp_end && !exp_is_fail,
                           mc >= exp_end && exp_is_fail};
                check($sformatf("status{valid,busy,done,fail} cycle %0d", mc), int'(cmp_act), int'(cmp_exp));
                if (exp_valid[mc])
                    check($sformatf("payload{reg,data} cycle %0d", mc),
                          int'({bus.reg_addr, bus.write_data}), int'({exp_reg[mc], exp_data[mc]}));
                if (mc >= exp_end && exp_is_fail)
                    check($sformatf("fail_index cycle %0d", mc), int'(fail_index), exp_fail_index);
                if (mc == 0) check("rom_addr after start", int'(rom_addr), 0);
            end
            mc++;
        end
    end

    task automatic run_walk(input string tag);
        build_model();
        @(negedge clk);
        start = 1'b1;
        att   = 0;
        @(posedge clk);
        mc       = 0;
        model_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (mc < exp_end + 20 && mc < MAXC) @(posedge clk);
        model_on = 1'b0;
        check({tag, " handshake attempts"}, att, exp_attempts);
        check({tag, " slav_addr"}, int'(bus.slav_addr), 'h1A);
        check({tag, " read_not_write"}, int'(bus.read_not_write), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " rom_addr"},    int'(rom_addr), 0);
        check({tag, " reg_addr"},    int'(bus.reg_addr), 0);
        check({tag, " write_data"},  int'(bus.write_data), 0);
        check({tag, " write_valid"}, int'(bus.write_valid), 0);
        check({tag, " busy"},        int'(busy), 0);
        check({tag, " done"},        int'(done), 0);
        check({tag, " fail"},        int'(fail), 0);
        check({tag, " fail_index"},  int'(fail_index), 0);
    endtask

    task automatic set_attempts(input int s, input int l);
        for (int i = 0; i < MAXA; i++) begin
            stall_a[i] = s; len_a[i] = l; nack_a[i] = 1'b0;
        end
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = e0; rom_mem[1] = e1; rom_mem[2] = e2; rom_mem[3] = e3; rom_mem[4] = e4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int n, r, vcount;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'hFFFF;
        set_attempts(0, 3);
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Three plain writes then the sentinel.
        load_rom(16'h1E00, 16'h0C00, 16'h0701, 16'hFFFF, 16'hFFFF);
        set_attempts(0, 3);
        run_walk("t1");
        check("t1 model first valid cycle", first_valid, 2);
        check("t1 model done cycle", exp_end, 38);
        check("t1 done level", int'(done), 1);

        // Delay entry of 5 units before a write.
        load_rom(16'hFE05, 16'h0C10, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_walk("t2");
        check("t2 model first valid cycle", first_valid, 105);

        // Master stalls ready for 7 cycles while the request is pending.
        load_rom(16'h2A5C, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_attempts(0, 3);
        stall_a[0] = 7;
        run_walk("t3");
        check("t3 model done cycle", exp_end, 21);

`ifdef I2C_CFG_RETRY_EN
        // NACK twice on entry 1, then recover.
        load_rom(16'h0C01, 16'h1A22, 16'h0705, 16'hFFFF, 16'hFFFF);
        set_attempts(0, 3);
        nack_a[1] = 1'b1; nack_a[2] = 1'b1;
        run_walk("t4");
        check("t4 model attempts", exp_attempts, 5);
        check("t4 done level", int'(done), 1);
        // Exhaust the retries on entry 0.
        load_rom(16'h3344, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_attempts(1, 2);
        for (int i = 0; i < 4; i++) nack_a[i] = 1'b1;
        run_walk("t4b");
        check("t4b model attempts", exp_attempts, 4);
        check("t4b fail level", int'(fail), 1);
`else
        // NACK on entry 2 is terminal, then a fresh start walks again from 0.
        load_rom(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'hFFFF);
        set_attempts(0, 2);
        nack_a[2] = 1'b1;
        run_walk("t5");
        check("t5 model fail index", exp_fail_index, 2);
        check("t5 fail_index port", int'(fail_index), 2);
        set_attempts(0, 2);
        run_walk("t5 restart");
        check("t5 restart done level", int'(done), 1);
`endif

        // Asynchronous reset while waiting for the master to finish.
        load_rom(16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_attempts(0, 6);
        @(negedge clk); start = 1'b1; att = 0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && !bus.write_valid; i++) @(negedge clk);
        check("t6 reached issue", int'(bus.write_valid), 1);
        repeat (3) @(negedge clk);
        check("t6 {valid,busy} in wait", int'({bus.write_valid, busy}), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("t6 async reset");
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.write_valid || busy) vcount++;
        end
        check("t6 idle cycles with activity after reset", vcount, 0);
        set_attempts(0, 2);
        run_walk("t6 after reset");

        // Randomized tables, including one full table without a sentinel.
        for (int it = 0; it < 12; it++) begin
            n = (it == 5) ? DEPTH : int'($urandom_range(1, 10));
            for (int i = 0; i < DEPTH; i++) begin
                r = int'($urandom_range(0, 9));
                if (i >= n)      rom_mem[i] = 16'hFFFF;
                else if (r == 0) rom_mem[i] = {8'hFE, 8'($urandom_range(0, 2))};
                else if (r == 1) rom_mem[i] = {8'hFF, 8'($urandom_range(0, 254))};
                else             rom_mem[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
            end
            for (int i = 0; i < MAXA; i++) begin
                stall_a[i] = int'($urandom_range(0, 3));
                len_a[i]   = int'($urandom_range(1, 5));
                nack_a[i]  = RETRY ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            end
            run_walk($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Sits directly upstream of the I2C write master in the microphone/codec path and drives its valid/ready write port.
- Walks a synchronous configuration ROM of {reg_addr, data} entries and issues one I2C register write per entry.
- Waits for each transfer to complete and checks the master's NACK flag. Supports embedded delay entries for codec settle times.
- Reports busy/done/fail to the top-level bring-up logic.

Parameters:
- SLAVE_ADDR, 7'h1A, 7-bit codec I2C address driven on slav_addr.
- ADDR_W, 6, ROM address width; the table holds at most 2**ADDR_W entries.
- GAP_CYCLES, 4, idle clk cycles inserted after every successful write before the next fetch.
- DELAY_UNIT, 20, clk cycles per unit of a delay entry (20 cycles = 1 ms at 20 kHz).
- MAX_RETRIES, 3, retries per entry after a NACK (used only with I2C_CFG_RETRY_EN).

Ports:
- clk, input, 1, system clock; the same 20 kHz clock as the I2C master.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a table walk from entry 0; ignored unless in IDLE, DONE or FAIL.
- rom_addr, output, ADDR_W, ROM index.
- rom_data, input, 16, {reg_addr[15:8], data[7:0]}; valid one cycle after rom_addr changes.
- slav_addr, output, 7, constant SLAVE_ADDR.
- read_not_write, output, 1, constant 0.
- reg_addr, output, 8, register address to the master.
- write_data, output, 8, data byte to the master.
- write_valid, output, 1, write request to the master.
- write_ready, input, 1, master idle/ready.
- error, input, 1, master NACK flag for the last transfer.
- busy, output, 1, high from start until DONE or FAIL.
- done, output, 1, level; high while in DONE.
- fail, output, 1, level; high while in FAIL.
- fail_index, output, ADDR_W, ROM index of the entry that failed.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; rom_addr=0, reg_addr=0, write_data=0, write_valid=0, busy=0, done=0, fail=0, fail_index=0, retry count=0.
- Reset mid-transfer drops write_valid immediately. The master is not reset by this block.
- States and transitions:
  - IDLE: start -> FETCH with rom_addr=0.
  - FETCH: one cycle for ROM latency -> DECODE.
  - DECODE: rom_data latched.
    - 16'hFFFF (end sentinel) -> DONE.
    - reg_addr==8'hFE (delay entry) -> DELAY, loading data*DELAY_UNIT into a 16-bit down-counter; data==0 skips straight to ADVANCE.
    - Otherwise -> ISSUE with reg_addr/write_data loaded.
  - ISSUE: write_valid=1. Outputs are held stable until write_valid&&write_ready; on that edge write_valid drops and the state -> WAIT_BUSY.
  - WAIT_BUSY: wait for write_ready==0, normally the next cycle -> WAIT_DONE.
  - WAIT_DONE: on the first cycle write_ready==1, sample error (the master clears its ack flags one edge later).
    - error==0 -> GAP.
    - error==1 -> the retry rule under Optional Feature.
  - GAP: count GAP_CYCLES cycles -> ADVANCE.
  - DELAY: count to 0 -> ADVANCE.
  - ADVANCE: rom_addr+1 -> FETCH. If rom_addr==2**ADDR_W-1, go to DONE instead (no wrap).
  - DONE / FAIL: hold. start restarts from entry 0 and clears done/fail.
- busy = state not in {IDLE, DONE, FAIL}.
- A start pulse while busy is ignored.
- write_valid is never asserted outside ISSUE.
- Latency:
  - start to first write_valid: 3 cycles (FETCH, DECODE, ISSUE entered).
  - A clean entry occupies ISSUE + master transfer + 1 + GAP_CYCLES + 1 (ADVANCE) + 2 (FETCH, DECODE).

Optional Feature:
- Macro: I2C_CFG_RETRY_EN.
- Defined: a NACK in WAIT_DONE increments the retry count. While count<=MAX_RETRIES the block waits GAP_CYCLES and re-enters ISSUE with the same entry. Otherwise it goes to FAIL with fail_index=rom_addr. The retry count clears on every ADVANCE and on start.
- Undefined: any NACK goes directly to FAIL with fail_index=rom_addr; no retry counter is synthesised.

Test Plan:
1. ROM {1E00, 0C00, 0701, FFFF}, master model ACKs all -> three handshakes with (reg,data)=(1E,00),(0C,00),(07,01); done=1 and busy=0 after the third transfer; no fourth write_valid.
2. Entry 0 = FE05 followed by 0C10 -> no write_valid for 100 cycles after DECODE of entry 0, then a write of (0C,10).
3. Master holds write_ready=0 for 7 cycles during ISSUE -> write_valid stays 1 with reg_addr/write_data unchanged until the handshake edge.
4. With I2C_CFG_RETRY_EN and MAX_RETRIES=3, NACK on the first 2 attempts of entry 1 -> 3 handshakes carrying identical data; success; walk continues; done=1.
5. Without I2C_CFG_RETRY_EN, NACK at entry 2 -> fail=1, fail_index=2, busy=0, no further write_valid. A new start restarts at rom_addr=0.
6. rst_n pulled low during WAIT_DONE -> all outputs at reset values asynchronously; after release, start is required before any write_valid.
